// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - piece codes, sequencer states and side-ownership helpers
package chess_pkg;

    localparam logic [3:0] EMPTY    = 4'd0;
    localparam logic [3:0] W_PAWN   = 4'd1;
    localparam logic [3:0] W_BISHOP = 4'd2;
    localparam logic [3:0] W_KNIGHT = 4'd3;
    localparam logic [3:0] W_ROOK   = 4'd4;
    localparam logic [3:0] W_QUEEN  = 4'd5;
    localparam logic [3:0] W_KING   = 4'd6;
    localparam logic [3:0] B_PAWN   = 4'd7;
    localparam logic [3:0] B_BISHOP = 4'd8;
    localparam logic [3:0] B_KNIGHT = 4'd9;
    localparam logic [3:0] B_ROOK   = 4'd10;
    localparam logic [3:0] B_QUEEN  = 4'd11;
    localparam logic [3:0] B_KING   = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SHOW,
        S_WRITE_DST,
        S_CLEAR_SRC,
        S_COMMIT,
        S_OVER
    } state_t;

    function automatic logic is_white(input logic [3:0] code);
        return (code >= W_PAWN) && (code <= W_KING);
    endfunction

    function automatic logic is_black(input logic [3:0] code);
        return (code >= B_PAWN) && (code <= B_KING);
    endfunction

endpackage

// File: rtl/promote_unit.sv
// rtl/promote_unit.sv - pawns reaching the far rank become queens of their colour
import chess_pkg::*;

module promote_unit (
    input  logic [3:0] code,
    input  logic [2:0] dst_row,
    output logic [3:0] promoted
);

    always_comb begin
        promoted = code;
        if (code == W_PAWN && dst_row == 3'd0) begin
            promoted = W_QUEEN;
        end else if (code == B_PAWN && dst_row == 3'd7) begin
            promoted = B_QUEEN;
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - click-driven select/validate/commit move controller
import chess_pkg::*;

module move_sequencer #(
    parameter int MOVE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 click_valid,
    input  logic [5:0]           click_pos,
    input  logic [7:0][7:0][3:0] board,
    input  logic [63:0]          possible_moves,
    output logic [3:0]           sel_figure,
    output logic [5:0]           sel_position,
    output logic [63:0]          highlight_mask,
    output logic                 board_we,
    output logic [5:0]           board_waddr,
    output logic [3:0]           board_wdata,
    output logic                 turn,
    output logic                 move_done,
    output logic                 illegal,
    output logic                 game_over
);

    localparam int CW = (MOVE_LAT > 1) ? $clog2(MOVE_LAT) : 1;

    state_t        state, state_next;
    logic [5:0]    src_pos, dst_pos;
    logic [3:0]    src_fig, cap;
    logic [CW-1:0] cnt;
    logic [3:0]    click_fig, promoted;
    logic          own, take_src, illegal_next, cap_king;

    assign click_fig = board[click_pos[5:3]][click_pos[2:0]];
    assign own       = turn ? is_black(click_fig) : is_white(click_fig);
    assign cap_king  = (cap == W_KING) || (cap == B_KING);

    promote_unit u_promote (
        .code     (src_fig),
        .dst_row  (dst_pos[5:3]),
        .promoted (promoted)
    );

    // Write port is decoded straight from the registered state.
    assign board_we    = (state == S_WRITE_DST) || (state == S_CLEAR_SRC);
    assign board_waddr = (state == S_WRITE_DST) ? dst_pos : src_pos;
    assign board_wdata = (state == S_WRITE_DST) ? promoted : EMPTY;
    assign move_done   = (state == S_COMMIT);

    always_comb begin
        state_next   = state;
        take_src     = 1'b0;
        illegal_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (click_valid) begin
                    if (own) begin
                        take_src   = 1'b1;
                        state_next = S_LOAD;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
            end
            S_LOAD: state_next = S_WAIT;
            S_WAIT: if (cnt == '0) state_next = S_SHOW;
            S_SHOW: begin
                if (click_valid) begin
                    if (click_pos == src_pos) begin
                        state_next = S_IDLE;
                    end else if (own) begin
                        take_src   = 1'b1;
                        state_next = S_LOAD;
                    end else if (highlight_mask[click_pos]) begin
                        state_next = S_WRITE_DST;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
            end
            S_WRITE_DST: state_next = S_CLEAR_SRC;
            S_CLEAR_SRC: state_next = S_COMMIT;
            S_COMMIT:    state_next = cap_king ? S_OVER : S_IDLE;
            S_OVER:      state_next = S_OVER;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            src_pos        <= '0;
            src_fig        <= EMPTY;
            dst_pos        <= '0;
            cap            <= EMPTY;
            cnt            <= '0;
            sel_figure     <= '0;
            sel_position   <= '0;
            highlight_mask <= '0;
            turn           <= 1'b0;
            illegal        <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            state   <= state_next;
            illegal <= illegal_next;
            if (take_src) begin
                src_pos      <= click_pos;
                src_fig      <= click_fig;
                sel_figure   <= click_fig;
                sel_position <= click_pos;
            end
            case (state)
                S_LOAD: cnt <= CW'(MOVE_LAT - 1);
                S_WAIT: begin
                    if (cnt == '0) highlight_mask <= possible_moves;
                    else           cnt <= cnt - CW'(1);
                end
                S_SHOW: begin
                    if (state_next == S_IDLE || state_next == S_LOAD) begin
                        highlight_mask <= '0;
                    end
                    if (state_next == S_WRITE_DST) begin
                        dst_pos <= click_pos;
                        cap     <= click_fig;
                    end
                end
                S_COMMIT: begin
                    highlight_mask <= '0;
                    turn           <= ~turn;
                    if (cap_king) game_over <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - scenario bench with write scoreboard and mask/board models
import chess_pkg::*;

module tb_move_sequencer;

    localparam int MOVE_LAT = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 click_valid;
    logic [5:0]           click_pos;
    logic [7:0][7:0][3:0] board;
    logic [63:0]          possible_moves;
    logic [3:0]           sel_figure;
    logic [5:0]           sel_position;
    logic [63:0]          highlight_mask;
    logic                 board_we;
    logic [5:0]           board_waddr;
    logic [3:0]           board_wdata;
    logic                 turn, move_done, illegal, game_over;

    move_sequencer #(.MOVE_LAT(MOVE_LAT)) dut (
        .clk(clk), .rst(rst), .click_valid(click_valid), .click_pos(click_pos),
        .board(board), .possible_moves(possible_moves),
        .sel_figure(sel_figure), .sel_position(sel_position),
        .highlight_mask(highlight_mask), .board_we(board_we),
        .board_waddr(board_waddr), .board_wdata(board_wdata), .turn(turn),
        .move_done(move_done), .illegal(illegal), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] addr;
        logic [3:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] mask_tbl [64];
    logic [63:0] pm1;
    int          checks = 0, failures = 0;
    int          illegal_cnt = 0, done_cnt = 0, we_cnt = 0;

    // One cycle: sample at negedge, run mask/board models, score writes.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        possible_moves = pm1;
        pm1 = mask_tbl[sel_position];
        if (illegal) illegal_cnt++;
        if (move_done) done_cnt++;
        if (board_we) begin
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%0h required=no write", board_waddr, board_wdata);
            end else begin
                e = exp_q.pop_front();
                if (board_waddr !== e.addr || board_wdata !== e.data) begin
                    failures++;
                    $display("FAIL write addr=%0d data=%0h required addr=%0d data=%0h",
                             board_waddr, board_wdata, e.addr, e.data);
                end
            end
            board[board_waddr[5:3]][board_waddr[2:0]] = board_wdata;
        end
    endtask

    task automatic click(input logic [5:0] p);
        click_valid = 1'b1;
        click_pos   = p;
        tick();
        click_valid = 1'b0;
    endtask

    task automatic put(input logic [5:0] p, input logic [3:0] code);
        board[p[5:3]][p[2:0]] = code;
    endtask

    task automatic push(input logic [5:0] a, input logic [3:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        click_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        board = '0;
    endtask

    task automatic wait_show();
        repeat (MOVE_LAT + 1) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sel_figure !== 4'd0) begin failures++; $display("FAIL reset_sel_figure got=%0h required=0", sel_figure); end
        checks++; if (sel_position !== 6'd0) begin failures++; $display("FAIL reset_sel_position got=%0d required=0", sel_position); end
        checks++; if (highlight_mask !== 64'd0) begin failures++; $display("FAIL reset_highlight got=%h required=0", highlight_mask); end
        checks++; if ({board_we, board_waddr, board_wdata} !== 11'd0) begin failures++; $display("FAIL reset_write_port got=%b required=0", {board_we, board_waddr, board_wdata}); end
        checks++; if ({turn, move_done, illegal, game_over} !== 4'd0) begin failures++; $display("FAIL reset_flags got=%b required=0000", {turn, move_done, illegal, game_over}); end
    endtask

    task automatic test_basic_move();
        int d0;
        logic [63:0] m;
        do_reset();
        put(52, W_PAWN);
        m = (64'd1 << 44) | (64'd1 << 36);
        mask_tbl[52] = m;
        click(52);
        checks++; if (sel_figure !== W_PAWN || sel_position !== 6'd52) begin failures++; $display("FAIL basic_sel got=%0h/%0d required=1/52", sel_figure, sel_position); end
        wait_show();
        checks++; if (highlight_mask !== 64'h0000101000000000) begin failures++; $display("FAIL basic_highlight got=%h required=%h", highlight_mask, m); end
        push(36, W_PAWN);
        push(52, EMPTY);
        d0 = done_cnt;
        click(36);
        repeat (3) tick();
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_move_done got=%0d required=1", done_cnt - d0); end
        checks++; if (turn !== 1'b1) begin failures++; $display("FAIL basic_turn got=%b required=1", turn); end
        checks++; if (highlight_mask !== 64'd0) begin failures++; $display("FAIL basic_highlight_clear got=%h required=0", highlight_mask); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL basic_writes_missing got=%0d pending required=0", exp_q.size()); end
        checks++; if (board[4][4] !== W_PAWN || board[6][4] !== EMPTY) begin failures++; $display("FAIL basic_board got=%0h/%0h required=1/0", board[4][4], board[6][4]); end
    endtask

    task automatic test_illegal_idle();
        int i0, w0;
        do_reset();
        put(12, B_PAWN);
        i0 = illegal_cnt;
        w0 = we_cnt;
        click(12);
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL idle_illegal_pulse got=%b required=1", illegal); end
        tick();
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL idle_illegal_width got=%b required=0", illegal); end
        repeat (3) tick();
        checks++; if (illegal_cnt - i0 !== 1 || we_cnt - w0 !== 0) begin failures++; $display("FAIL idle_illegal_counts got illegal=%0d we=%0d required 1/0", illegal_cnt - i0, we_cnt - w0); end
        checks++; if (sel_position !== 6'd0) begin failures++; $display("FAIL idle_no_select got=%0d required=0", sel_position); end
    endtask

    task automatic test_show_illegal();
        int i0, w0;
        logic [63:0] m;
        board = '0;
        put(27, W_KNIGHT);
        m = (64'd1 << 10) | (64'd1 << 12);
        mask_tbl[27] = m;
        click(27);
        wait_show();
        checks++; if (highlight_mask !== m) begin failures++; $display("FAIL show_highlight got=%h required=%h", highlight_mask, m); end
        i0 = illegal_cnt;
        click(20);
        checks++; if (illegal !== 1'b1 || highlight_mask !== m) begin failures++; $display("FAIL show_illegal got illegal=%b mask=%h required 1/%h", illegal, highlight_mask, m); end
        click(27);
        checks++; if (highlight_mask !== 64'd0) begin failures++; $display("FAIL show_deselect got=%h required=0", highlight_mask); end
        i0 = illegal_cnt;
        w0 = we_cnt;
        click(10);
        tick();
        checks++; if (illegal_cnt - i0 !== 1 || we_cnt - w0 !== 0) begin failures++; $display("FAIL show_back_to_idle got illegal=%0d we=%0d required 1/0", illegal_cnt - i0, we_cnt - w0); end
    endtask

    task automatic test_promotion();
        do_reset();
        put(8, W_PAWN);
        put(55, B_PAWN);
        mask_tbl[8]  = 64'd1;
        mask_tbl[55] = 64'd1 << 63;
        click(8);
        wait_show();
        push(0, W_QUEEN);
        push(8, EMPTY);
        click(0);
        repeat (3) tick();
        checks++; if (turn !== 1'b1) begin failures++; $display("FAIL promo_turn_white got=%b required=1", turn); end
        click(55);
        wait_show();
        push(63, B_QUEEN);
        push(55, EMPTY);
        click(63);
        repeat (3) tick();
        checks++; if (turn !== 1'b0) begin failures++; $display("FAIL promo_turn_black got=%b required=0", turn); end
        checks++; if (board[0][0] !== W_QUEEN || board[7][7] !== B_QUEEN) begin failures++; $display("FAIL promo_board got=%0h/%0h required=5/b", board[0][0], board[7][7]); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL promo_writes_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_king_capture();
        int d0, i0, w0;
        do_reset();
        put(60, W_QUEEN);
        put(4, B_KING);
        mask_tbl[60] = 64'd1 << 4;
        click(60);
        wait_show();
        push(4, W_QUEEN);
        push(60, EMPTY);
        d0 = done_cnt;
        click(4);
        repeat (3) tick();
        checks++; if (done_cnt - d0 !== 1 || game_over !== 1'b1) begin failures++; $display("FAIL capture got done=%0d game_over=%b required 1/1", done_cnt - d0, game_over); end
        i0 = illegal_cnt;
        w0 = we_cnt;
        click(4);
        click(60);
        click(12);
        repeat (4) tick();
        checks++; if (illegal_cnt - i0 !== 0 || we_cnt - w0 !== 0) begin failures++; $display("FAIL over_ignores got illegal=%0d we=%0d required 0/0", illegal_cnt - i0, we_cnt - w0); end
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL over_sticky got=%b required=1", game_over); end
    endtask

    task automatic test_reset_mid_write();
        int i0;
        do_reset();
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_clears_over got=%b required=0", game_over); end
        put(56, W_ROOK);
        mask_tbl[56] = 64'd1 << 48;
        i0 = illegal_cnt;
        click(56);
        click(3);
        click(3);
        tick();
        checks++; if (illegal_cnt - i0 !== 0 || highlight_mask !== (64'd1 << 48)) begin failures++; $display("FAIL wait_clicks_dropped got illegal=%0d mask=%h required 0/%h", illegal_cnt - i0, highlight_mask, 64'd1 << 48); end
        push(48, W_ROOK);
        click(48);
        checks++; if (board_we !== 1'b1) begin failures++; $display("FAIL mid_write_we got=%b required=1", board_we); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({board_we, turn, move_done} !== 3'b000 || highlight_mask !== 64'd0) begin failures++; $display("FAIL mid_write_reset got we/turn/done=%b mask=%h required 000/0", {board_we, turn, move_done}, highlight_mask); end
        i0 = illegal_cnt;
        click(40);
        tick();
        checks++; if (illegal_cnt - i0 !== 1) begin failures++; $display("FAIL mid_write_idle got=%0d required=1", illegal_cnt - i0); end
        checks++; if (board[6][0] !== W_ROOK || board[7][0] !== W_ROOK || exp_q.size() !== 0) begin failures++; $display("FAIL mid_write_partial got=%0h/%0h pending=%0d required 4/4/0", board[6][0], board[7][0], exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        click_valid = 1'b0;
        click_pos = '0;
        board = '0;
        possible_moves = '0;
        pm1 = '0;
        for (int i = 0; i < 64; i++) mask_tbl[i] = '0;
        test_reset();
        test_basic_move();
        test_illegal_idle();
        test_show_illegal();
        test_promotion();
        test_king_capture();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
